// File: rtl/scheduler_acc_selector_pkg.sv
// Shared types and sched-info word field layout for the accelerator selector.
package scheduler_acc_selector_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int unsigned FIRST_LSB = 0;

    function automatic int unsigned first_w(input int unsigned acc_bits);
        return acc_bits;
    endfunction

    function automatic int unsigned num_lsb(input int unsigned acc_bits);
        return FIRST_LSB + acc_bits;
    endfunction

    // One extra bit so a type can hold 2**ACC_BITS instances.
    function automatic int unsigned num_w(input int unsigned acc_bits);
        return acc_bits + 1;
    endfunction

endpackage

// File: rtl/scheduler_acc_selector_offset_table.sv
// Per-type round-robin offset registers: async reset to 0, one comb read, one write port.
module sched_rr_offset_table #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data
);

    logic [DEPTH-1:0][W-1:0] tbl_q;

    assign rd_data = tbl_q[rd_addr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tbl_q <= '0;
        end else if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/scheduler_acc_selector.sv
// Looks up an accelerator type's sched-info over memory port B and returns the ID to dispatch to.
// Define SCHED_ROUND_ROBIN_EN to rotate over a type's instances; otherwise first_acc_id is returned.
module scheduler_acc_selector
    import scheduler_acc_selector_pkg::*;
#(
    parameter int MAX_ACC_TYPES = 16,
    parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
    parameter int DATA_BITS     = 48,
    parameter int ACC_BITS      = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ACC_TYPE_BITS-1:0] req_acc_type,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ACC_BITS-1:0]      resp_acc_id,
    output logic                     resp_err,
    output logic [ACC_TYPE_BITS-1:0] scheduleData_portB_addr,
    output logic                     scheduleData_portB_en,
    input  logic [DATA_BITS-1:0]     scheduleData_portB_dout
);

    localparam int NUM_LSB = num_lsb(ACC_BITS);
    localparam int NUM_W   = num_w(ACC_BITS);
    localparam int FW      = first_w(ACC_BITS);

    state_e                   state_q;
    logic [ACC_TYPE_BITS-1:0] type_q;
    logic [ACC_BITS-1:0]      id_q;
    logic                     err_q;

    logic                     accept;
    logic [ACC_BITS-1:0]      first;
    logic [NUM_W-1:0]         num;
    logic [ACC_BITS-1:0]      off;

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_acc_id = id_q;
    assign resp_err    = err_q;
    assign accept      = req_valid & req_ready;

    // Reset forces state to IDLE asynchronously, so the read enable is gated explicitly.
    assign scheduleData_portB_en   = accept & rstn;
    assign scheduleData_portB_addr = req_acc_type;

    assign first = scheduleData_portB_dout[FIRST_LSB +: FW];
    assign num   = scheduleData_portB_dout[NUM_LSB +: NUM_W];

`ifdef SCHED_ROUND_ROBIN_EN
    logic [ACC_BITS-1:0] off_raw;
    logic [ACC_BITS-1:0] off_q;
    logic [ACC_BITS-1:0] off_nxt;
    logic [NUM_W-1:0]    num_q;
    logic                off_wr;
    logic                unused_hi;

    assign unused_hi = ^scheduleData_portB_dout[DATA_BITS-1:NUM_LSB+NUM_W];

    sched_rr_offset_table #(
        .DEPTH (MAX_ACC_TYPES),
        .AW    (ACC_TYPE_BITS),
        .W     (ACC_BITS)
    ) u_off_tbl (
        .clk     (clk),
        .rstn    (rstn),
        .rd_addr (type_q),
        .rd_data (off_raw),
        .wr_en   (off_wr),
        .wr_addr (type_q),
        .wr_data (off_nxt)
    );

    // A stale offset beyond a shrunk instance count restarts at the first instance.
    assign off     = ({1'b0, off_raw} >= num) ? '0 : off_raw;
    assign off_nxt = (({1'b0, off_q} + NUM_W'(1)) == num_q) ? '0 : off_q + 1'b1;
    assign off_wr  = resp_valid & resp_ready & ~err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            off_q <= '0;
            num_q <= '0;
        end else if (state_q == WAIT) begin
            off_q <= off;
            num_q <= num;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^{scheduleData_portB_dout[DATA_BITS-1:NUM_LSB+NUM_W], type_q};
    assign off       = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            type_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        type_q  <= req_acc_type;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (num == '0) begin
                        err_q <= 1'b1;
                        id_q  <= '0;
                    end else begin
                        err_q <= 1'b0;
                        id_q  <= first + off;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scheduler_acc_selector.sv
// Directed plus randomized checks of scheduler_acc_selector against a per-type instance model.
module tb_scheduler_acc_selector;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_acc_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_acc_id;
    logic        resp_err;
    logic [3:0]  addr;
    logic        en;
    logic [47:0] dout = '0;

    logic [47:0] mem [16];
    int          m_first [16];
    int          m_num   [16];
    int          m_off   [16];
    int          nvec = 0;
    int          nmis = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (en) dout <= mem[addr];

    scheduler_acc_selector dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_acc_type            (req_acc_type),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_acc_id             (resp_acc_id),
        .resp_err                (resp_err),
        .scheduleData_portB_addr (addr),
        .scheduleData_portB_en   (en),
        .scheduleData_portB_dout (dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int t, input int first, input int num);
        logic [38:0] hi;
        logic [4:0]  n5;
        logic [3:0]  f4;
        hi = 39'($urandom);
        n5 = 5'(num);
        f4 = 4'(first);
        mem[t]     = {hi, n5, f4};
        m_first[t] = first;
        m_num[t]   = num;
    endtask

    task automatic do_req(input int t, input int hold);
        int  o;
        int  exp_id;
        bit  exp_err;
        @(negedge clk);
        req_valid    = 1'b1;
        req_acc_type = 4'(t);
        #1;
        chk("idle_req_ready", req_ready, 1);
        chk("accept_en", en, 1);
        chk("accept_addr", addr, t);
        exp_err = (m_num[t] == 0);
        o = (m_off[t] >= m_num[t]) ? 0 : m_off[t];
`ifndef SCHED_ROUND_ROBIN_EN
        o = 0;
`endif
        exp_id = exp_err ? 0 : (m_first[t] + o) % 16;
        @(posedge clk); #1;
        chk("wait_resp_valid", resp_valid, 0);
        chk("wait_req_ready", req_ready, 0);
        chk("wait_en", en, 0);
        @(posedge clk); #1;
        chk("resp_valid_lat2", resp_valid, 1);
        chk("resp_id", resp_acc_id, exp_id);
        chk("resp_err", resp_err, exp_err);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_id", resp_acc_id, exp_id);
            chk("hold_err", resp_err, exp_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_en", en, 0);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
`ifdef SCHED_ROUND_ROBIN_EN
        if (!exp_err) m_off[t] = (o + 1 == m_num[t]) ? 0 : o + 1;
`endif
    endtask

    initial begin
        rstn         = 1'b0;
        req_valid    = 1'b1;
        req_acc_type = 4'd3;
        resp_ready   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setw(i, $urandom_range(0, 15), $urandom_range(1, 5));
            m_off[i] = 0;
        end
        #12;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_en_gated", en, 0);
        chk("rst_id", resp_acc_id, 0);
        chk("rst_err", resp_err, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // T1: rotation over three instances
        setw(3, 5, 3);
        for (int i = 0; i < 4; i++) do_req(3, 0);

        // T2: zero instances gives an error and does not disturb the offset
        setw(0, 7, 0);
        do_req(0, 0);
        setw(0, 2, 2);
        do_req(0, 0);

        // T3: independent offsets per type
        setw(1, 0, 2);
        setw(2, 8, 4);
        for (int i = 0; i < 3; i++) begin
            do_req(1, 0);
            do_req(2, 0);
        end

        // T4: consumer back-pressure
        do_req(2, 5);

        // T5: ID wrap and shrink clamp
        setw(4, 14, 4);
        for (int i = 0; i < 3; i++) do_req(4, 0);
        setw(4, 14, 1);
        do_req(4, 0);

        // T6: reset while the lookup is in flight
        @(negedge clk);
        req_valid    = 1'b1;
        req_acc_type = 4'd3;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", resp_valid, 0);
        chk("midrst_en", en, 0);
        chk("midrst_id", resp_acc_id, 0);
        @(negedge clk);
        req_valid = 1'b0;
        rstn      = 1'b1;
        for (int i = 0; i < 16; i++) m_off[i] = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_resp", resp_valid, 0);
        end
        do_req(3, 0);

        // Randomized traffic with occasional sched-info rewrites
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                setw($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 5));
            do_req($urandom_range(0, 7), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
